// File: rtl/instr_fetch_if.sv
// Fetch-stage port bundle: redirect input, imem req/rsp channels, decode channel.
// master = fetch unit, slave = its environment (execute, imem, decode).
interface instr_fetch_if #(
  parameter int XLEN = 32
);
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_data;

  logic            if_valid;
  logic            if_ready;
  logic [XLEN-1:0] if_pc;
  logic [31:0]     if_instr;

  modport master (
    input  redirect_valid, redirect_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  if_ready,
    output imem_req_valid, imem_req_addr,
    output if_valid, if_pc, if_instr
  );

  modport slave (
    output redirect_valid, redirect_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output if_ready,
    input  imem_req_valid, imem_req_addr,
    input  if_valid, if_pc, if_instr
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch: owns the PC, issues word reads to imem under a credit
// limit, buffers {pc,instr} in a small FIFO and hands them to decode.
// Taken branches flush the FIFO and mark in-flight reads for discard.
module instr_fetch #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 4
) (
  input  logic          clk,
  input  logic          rst,
  instr_fetch_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } entry_t;

  entry_t          fifo_q [DEPTH];
  logic [AW-1:0]   rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]   count_q;   // words buffered
  logic [CW-1:0]   live_q;    // in-flight reads whose data will be kept
  logic [CW-1:0]   drop_q;    // in-flight reads issued before a redirect
  logic [XLEN-1:0] pc_q;      // next address to request
  logic [XLEN-1:0] rsp_pc_q;  // PC belonging to the next kept response

  logic [CW-1:0]   credit;
  logic            req_fire, push, pop;
  logic [XLEN-1:0] redirect_tgt;

  // Buffered plus in-flight words may never exceed the FIFO size, so every
  // kept response is guaranteed a slot without back-pressuring imem.
  assign credit       = count_q + live_q;
  assign redirect_tgt = bus.redirect_pc & ~XLEN'(3);

  assign bus.imem_req_valid = !rst && !bus.redirect_valid && (credit < DEPTH_C);
  assign bus.imem_req_addr  = pc_q;
  assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;

  assign push = bus.imem_rsp_valid && (drop_q == '0);

  assign bus.if_valid = (count_q != '0) && !bus.redirect_valid && !rst;
  assign bus.if_pc    = fifo_q[rd_ptr_q].pc;
  assign bus.if_instr = fifo_q[rd_ptr_q].instr;
  assign pop          = bus.if_valid && bus.if_ready;

  // Control state: redirect outranks issue, push and pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q     <= RESET_PC;
      rsp_pc_q <= RESET_PC;
      count_q  <= '0;
      live_q   <= '0;
      drop_q   <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else if (bus.redirect_valid) begin
      pc_q     <= redirect_tgt;
      rsp_pc_q <= redirect_tgt;
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      live_q   <= '0;
      // Everything still outstanding becomes stale; a word arriving right
      // now is already being thrown away, so it is not counted again.
      drop_q   <= live_q + drop_q - CW'(bus.imem_rsp_valid);
    end else begin
      if (req_fire) pc_q <= pc_q + XLEN'(4);
      if (push) begin
        rsp_pc_q <= rsp_pc_q + XLEN'(4);
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      if (bus.imem_rsp_valid && (drop_q != '0)) drop_q <= drop_q - CW'(1);
      live_q  <= live_q + CW'(req_fire) - CW'(push);
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  // FIFO storage; no reset needed since count gates visibility.
  always_ff @(posedge clk) begin
    if (!rst && !bus.redirect_valid && push)
      fifo_q[wr_ptr_q] <= '{pc: rsp_pc_q, instr: bus.imem_rsp_data};
  end

`ifndef SYNTHESIS
  a_rsp_expected: assert property (@(posedge clk) disable iff (rst)
    !(bus.imem_rsp_valid && (live_q == '0) && (drop_q == '0)));
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(!bus.redirect_valid && push && !pop && (count_q == DEPTH_C)));
`endif
endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: imem model with programmable latency, a program-order
// reference model checked every cycle, directed corner sequences, a redirect
// alignment table and a randomized phase.
module tb_instr_fetch;
  localparam int          XLEN     = 32;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  instr_fetch_if #(.XLEN(XLEN)) bus ();
  instr_fetch #(.XLEN(XLEN), .RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int n_chk = 0, n_fail = 0;
  int cyc = 0, lat = 1;

  // imem model: in-order queue of accepted reads, tagged with redirect epoch
  typedef struct { logic [31:0] addr; int due; int epoch; } req_t;
  req_t pend[$];
  int   epoch = 0;

  // reference model of what decode and imem should see
  logic [31:0] m_req_pc = RESET_PC, m_dec_pc = RESET_PC;
  int          m_occ = 0, m_avail = 0;

  // per-cycle stimulus knobs
  logic        k_rst = 1'b1, k_ready = 1'b1, k_if_ready = 1'b1, k_redir = 1'b0;
  logic [31:0] k_rpc = '0;

  // last-cycle observations for directed checks
  logic        last_fire, last_ifv, last_reqv;
  logic [31:0] last_addr, last_if_pc, last_if_instr;
  int          fires = 0, pops = 0;

  function automatic logic [31:0] imem_word(logic [31:0] a);
    return 32'h1000 + (a >> 2);
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    logic        rv, fire, pop, live_rsp;
    logic [31:0] tgt;
    @(negedge clk);
    rst                = k_rst;
    bus.imem_req_ready = k_ready;
    bus.if_ready       = k_if_ready;
    bus.redirect_valid = k_redir && !k_rst;
    bus.redirect_pc    = k_rpc;
    rv = !k_rst && (pend.size() > 0) && (pend[0].due <= cyc);
    bus.imem_rsp_valid = rv;
    bus.imem_rsp_data  = rv ? imem_word(pend[0].addr) : 32'hdead_beef;
    #1;
    check("req_valid", 32'(bus.imem_req_valid),
          32'(!k_rst && !bus.redirect_valid && (m_occ < DEPTH)));
    if (bus.imem_req_valid) check("req_addr", bus.imem_req_addr, m_req_pc);
    check("if_valid", 32'(bus.if_valid),
          32'(!k_rst && !bus.redirect_valid && (m_avail > 0)));
    if (bus.if_valid) begin
      check("if_pc", bus.if_pc, m_dec_pc);
      check("if_instr", bus.if_instr, imem_word(m_dec_pc));
    end
    fire          = bus.imem_req_valid && k_ready;
    pop           = bus.if_valid && k_if_ready;
    last_fire     = fire;
    last_reqv     = bus.imem_req_valid;
    last_addr     = bus.imem_req_addr;
    last_ifv      = bus.if_valid;
    last_if_pc    = bus.if_pc;
    last_if_instr = bus.if_instr;
    fires += int'(fire);
    pops  += int'(pop);
    @(posedge clk);
    if (k_rst) begin
      pend.delete();
      epoch++;
      m_req_pc = RESET_PC; m_dec_pc = RESET_PC; m_occ = 0; m_avail = 0;
    end else begin
      live_rsp = rv && (pend[0].epoch == epoch) && !bus.redirect_valid;
      if (rv) void'(pend.pop_front());
      if (bus.redirect_valid) begin
        epoch++;
        tgt = {k_rpc[31:2], 2'b00};
        m_req_pc = tgt; m_dec_pc = tgt; m_occ = 0; m_avail = 0;
      end else begin
        if (fire) begin
          pend.push_back('{addr: bus.imem_req_addr, due: cyc + lat, epoch: epoch});
          m_req_pc += 32'd4;
          m_occ++;
        end
        if (live_rsp) m_avail++;
        if (pop) begin
          m_avail--; m_occ--; m_dec_pc += 32'd4;
        end
      end
    end
    cyc++;
  endtask

  task automatic do_reset(int l);
    k_rst = 1'b1; k_redir = 1'b0;
    repeat (3) tick();
    lat = l; k_rst = 1'b0;
  endtask

  task automatic wait_ifv(int limit, output logic seen);
    seen = 1'b0;
    for (int i = 0; i < limit; i++) begin
      tick();
      if (last_ifv) begin seen = 1'b1; break; end
    end
  endtask

  typedef struct { logic [31:0] rpc; logic [31:0] exp0; logic [31:0] exp1; } vec_t;
  vec_t vecs [5];

  initial begin
    logic seen;
    int   f0, p0;
    rst = 1'b1;
    bus.redirect_valid = 1'b0; bus.redirect_pc = '0;
    bus.imem_req_ready = 1'b0; bus.imem_rsp_valid = 1'b0; bus.imem_rsp_data = '0;
    bus.if_ready = 1'b0;

    vecs[0] = '{32'h0000_0083, 32'h0000_0080, 32'h0000_0084};
    vecs[1] = '{32'h0000_0040, 32'h0000_0040, 32'h0000_0044};
    vecs[2] = '{32'h0000_0007, 32'h0000_0004, 32'h0000_0008};
    vecs[3] = '{32'h1234_5679, 32'h1234_5678, 32'h1234_567c};
    vecs[4] = '{32'hffff_fffe, 32'hffff_fffc, 32'h0000_0000};

    // reset hold, then first requests 0, 4, 8
    k_ready = 1'b1; k_if_ready = 1'b1;
    do_reset(1);
    check("t1_reqv_in_rst", 32'(last_reqv), 32'd0);
    check("t1_ifv_in_rst", 32'(last_ifv), 32'd0);
    tick(); check("t1_addr0", last_fire ? last_addr : 32'hffff_ffff, 32'h0);
    tick(); check("t1_addr1", last_fire ? last_addr : 32'hffff_ffff, 32'h4);
    tick(); check("t1_addr2", last_fire ? last_addr : 32'hffff_ffff, 32'h8);

    // streaming L=1: one instruction per cycle once filled
    do_reset(1);
    repeat (10) tick();
    p0 = pops;
    repeat (30) tick();
    check("t2_pops", 32'(pops - p0), 32'd30);
    check("t2_last_pc", last_if_pc, 32'h94);
    check("t2_last_instr", last_if_instr, 32'h1025);

    // backpressure: credit stops issue at 4, head holds
    do_reset(1);
    k_if_ready = 1'b0;
    f0 = fires;
    repeat (10) tick();
    check("t3_fires", 32'(fires - f0), 32'd4);
    check("t3_reqv_low", 32'(last_reqv), 32'd0);
    check("t3_hold_pc", last_if_pc, 32'h0);
    check("t3_hold_instr", last_if_instr, 32'h1000);
    k_if_ready = 1'b1;
    repeat (15) tick();

    // redirect with two reads in flight, L=3
    do_reset(3);
    tick(); tick();
    k_redir = 1'b1; k_rpc = 32'h40; tick();
    k_redir = 1'b0;
    tick(); check("t4_addr", last_fire ? last_addr : 32'hffff_ffff, 32'h40);
    wait_ifv(20, seen);
    check("t4_seen", 32'(seen), 32'd1);
    if (seen) check("t4_first_pc", last_if_pc, 32'h40);
    repeat (10) tick();

    // redirect coinciding with a response and a pop
    do_reset(1);
    repeat (6) tick();
    k_redir = 1'b1; k_rpc = 32'h83; tick();
    check("t5_ifv_redir", 32'(last_ifv), 32'd0);
    k_redir = 1'b0;
    tick(); check("t5_addr", last_fire ? last_addr : 32'hffff_ffff, 32'h80);
    wait_ifv(10, seen);
    check("t5_seen", 32'(seen), 32'd1);
    if (seen) begin
      check("t5_first_pc", last_if_pc, 32'h80);
      check("t5_first_instr", last_if_instr, 32'h1020);
    end

    // reset with FIFO full
    do_reset(1);
    k_if_ready = 1'b0;
    repeat (12) tick();
    check("t6_full_ifv", 32'(last_ifv), 32'd1);
    k_rst = 1'b1; tick();
    k_rst = 1'b0; tick();
    check("t6_ifv", 32'(last_ifv), 32'd0);
    check("t6_addr", last_fire ? last_addr : 32'hffff_ffff, RESET_PC);
    k_if_ready = 1'b1;

    // redirect alignment and PC wrap table
    do_reset(1);
    repeat (4) tick();
    for (int i = 0; i < 5; i++) begin
      k_redir = 1'b1; k_rpc = vecs[i].rpc; tick();
      k_redir = 1'b0;
      tick(); check("tbl_addr0", last_fire ? last_addr : 32'hffff_ffff, vecs[i].exp0);
      tick(); check("tbl_addr1", last_fire ? last_addr : 32'hffff_ffff, vecs[i].exp1);
      repeat (3) tick();
    end

    // randomized traffic against the reference model
    do_reset(2);
    for (int i = 0; i < 3000; i++) begin
      if (i % 750 == 0) lat = 1 + (i / 750);
      k_ready    = ($urandom_range(0, 3) != 0);
      k_if_ready = ($urandom_range(0, 3) != 0);
      k_redir    = ($urandom_range(0, 15) == 0);
      k_rpc      = $urandom;
      k_rst      = ($urandom_range(0, 299) == 0);
      tick();
    end
    k_rst = 1'b0; k_redir = 1'b0;
    repeat (5) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end
endmodule
